// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size decode used by the controller and the load extender.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic       is_signed;
    logic [2:0] nbytes;
  } lsu_size_t;

  // Stores only have the three signed encodings; loads add the unsigned ones.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    if (we) begin
      return funct3 inside {F3_B, F3_H, F3_W};
    end
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // The low two funct3 bits carry the size for every legal encoding.
  function automatic logic [2:0] f3_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic lsu_size_t decode_size(input logic [2:0] funct3, input logic we);
    lsu_size_t info;
    info.legal     = f3_legal(funct3, we);
    info.is_signed = (funct3 == F3_B) || (funct3 == F3_H);
    info.nbytes    = f3_bytes(funct3);
    return info;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Aligns the (possibly two-word) load data to the access offset, trims it to
// the access size and sign- or zero-extends it to a full word.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT3_WIDTH = 3,
  parameter int BYTE_WIDTH   = 8
) (
  input  logic [2*DATA_WIDTH-1:0] words,
  input  logic [1:0]              off,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  output logic [DATA_WIDTH-1:0]   result
);

  lsu_size_t             info;
  logic [DATA_WIDTH-1:0] shifted;

  assign info    = decode_size(funct3, 1'b0);
  assign shifted = DATA_WIDTH'(words >> (off * BYTE_WIDTH));

  // Select the byte/half/word and extend; anything not a legal load yields 0.
  always_comb begin
    result = '0;
    if (info.legal) begin
      case (info.nbytes)
        3'd1: result = {{(DATA_WIDTH-BYTE_WIDTH){info.is_signed & shifted[BYTE_WIDTH-1]}},
                        shifted[BYTE_WIDTH-1:0]};
        3'd2: result = {{(DATA_WIDTH-2*BYTE_WIDTH){info.is_signed & shifted[2*BYTE_WIDTH-1]}},
                        shifted[2*BYTE_WIDTH-1:0]};
        default: result = shifted;
      endcase
    end
  end

endmodule

// File: rtl/lsu_split_ctrl.sv
// Load/store initiator: takes one core access per handshake and turns it into
// one or two word-aligned memory cycles, splitting accesses that straddle a
// word boundary, then returns extended load data with a one-cycle pulse.
module lsu_split_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int FUNCT3_WIDTH = 3,
  parameter int BYTE_WIDTH   = 8
) (
  input  logic                             CLK,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [FUNCT3_WIDTH-1:0]          req_funct3,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             resp_err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH/BYTE_WIDTH-1:0] mem_be,
  output logic                             mem_we,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  lsu_state_e state_q, state_d;

  logic                    we_q, we_d;
  logic [FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   w0_q, w0_d;
  logic [DATA_WIDTH-1:0]   w1_q, w1_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;

  logic                    handshake;
  logic                    req_legal;
  logic [2:0]              acc_bytes;
  logic [1:0]              off;
  logic                    crossing;
  logic [2*LANES-1:0]      be_base;
  logic [2*LANES-1:0]      be8;
  logic [2*DATA_WIDTH-1:0] wd64;
  logic [ADDR_WIDTH-1:0]   word0;
  logic [ADDR_WIDTH-1:0]   word1;
  logic [2*DATA_WIDTH-1:0] ext_words;
  logic [DATA_WIDTH-1:0]   ext_result;

  assign handshake = req_valid & req_ready;
  assign req_legal = f3_legal(req_funct3, req_we);
  assign acc_bytes = f3_bytes(funct3_q);
  assign off       = addr_q[1:0];
  assign crossing  = ({2'b00, off} + {1'b0, acc_bytes}) > 4'd4;
  assign be8       = be_base << off;
  assign wd64      = {{DATA_WIDTH{1'b0}}, wdata_q} << (off * BYTE_WIDTH);
  assign word0     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign word1     = word0 + ADDR_WIDTH'(4);

  // In ACC1 the live word is the upper half; in ACC0 the upper half is zero.
  assign ext_words = (state_q == ACC1) ? {mem_rdata, w0_q}
                                       : {{DATA_WIDTH{1'b0}}, mem_rdata};

  // Unshifted lane mask for the access size.
  always_comb begin
    case (acc_bytes)
      3'd1:    be_base = 8'h01;
      3'd2:    be_base = 8'h03;
      default: be_base = 8'h0F;
    endcase
  end

  lsu_load_extend #(
    .DATA_WIDTH   (DATA_WIDTH),
    .FUNCT3_WIDTH (FUNCT3_WIDTH),
    .BYTE_WIDTH   (BYTE_WIDTH)
  ) u_load_extend (
    .words  (ext_words),
    .off    (off),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  // State register; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: illegal requests skip the memory cycles entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (handshake) state_d = req_legal ? ACC0 : RESP;
      ACC0: state_d = crossing ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, read-word capture and response data registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Response registers only change on the transition into RESP so they hold
  // their value between responses.
  always_comb begin
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    w0_d         = w0_q;
    w1_d         = w1_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          w0_d     = '0;
          w1_d     = '0;
          if (!req_legal) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end
        end
      end
      ACC0: begin
        w0_d = mem_rdata;
        if (!crossing) begin
          resp_rdata_d = we_q ? '0 : ext_result;
          resp_err_d   = 1'b0;
        end
      end
      ACC1: begin
        w1_d         = mem_rdata;
        resp_rdata_d = we_q ? '0 : ext_result;
        resp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Memory port and handshake outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
    mem_addr   = '0;
    mem_be     = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      ACC0: begin
        mem_addr  = word0;
        mem_be    = be8[LANES-1:0];
        mem_we    = we_q;
        mem_wdata = we_q ? wd64[DATA_WIDTH-1:0] : '0;
      end
      ACC1: begin
        mem_addr  = word1;
        mem_be    = be8[2*LANES-1:LANES];
        mem_we    = we_q;
        mem_wdata = we_q ? wd64[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Directed self-checking bench for lsu_split_ctrl with a small byte-lane
// memory model attached to the memory port.
module tb_lsu_split_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_words [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] c_addr [1:3];
  logic [3:0]  c_be   [1:3];
  logic        c_we   [1:3];
  logic [31:0] c_wd   [1:3];
  logic [31:0] r_rdata;
  logic        r_err;

  always #5 CLK = ~CLK;

  lsu_split_ctrl dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: 256 words, combinational read, lane-wise commit on the edge.
  assign mem_rdata = mem_words[mem_addr[9:2]];

  always @(posedge CLK) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_be[l]) mem_words[mem_addr[9:2]][l*8 +: 8] <= mem_wdata[l*8 +: 8];
      end
    end
  end

  // Issue one access starting at posedge+1 while idle; records the memory port
  // in each cycle after the handshake and returns the resp_valid latency
  // (-1 on timeout). Returns one cycle after the response cycle.
  task automatic run_access(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int lat);
    for (int i = 1; i <= 3; i++) begin
      c_addr[i] = 32'h0; c_be[i] = 4'h0; c_we[i] = 1'b0; c_wd[i] = 32'h0;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge CLK); #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFF0;
    req_wdata  = 32'h5555_5555;
    lat = 1;
    while (1) begin
      if (lat <= 3) begin
        c_addr[lat] = mem_addr; c_be[lat] = mem_be; c_we[lat] = mem_we; c_wd[lat] = mem_wdata;
      end
      if (resp_valid) break;
      if (lat >= 8) break;
      @(posedge CLK); #1;
      lat++;
    end
    if (!resp_valid) begin
      lat = -1;
    end
    r_rdata = resp_rdata;
    r_err   = resp_err;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we);
    end
    rst_n = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL reset_handshake: got rdy/vld/err=%b want 100", {req_ready, resp_valid, resp_err});
    end
    n_cmp++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0", resp_rdata, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (mem_be !== 4'h0 || mem_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_be_we: got be=%b we=%b want 0000/0", mem_be, mem_we);
    end
  endtask

  task automatic test_word;
    int lat;
    run_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_fail++; $display("[TB] FAIL sw_latency: got %0d want 2", lat);
    end
    n_cmp++;
    if (c_addr[1] !== 32'h100 || c_be[1] !== 4'hF || c_we[1] !== 1'b1 || c_wd[1] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL sw_cycle: got addr=%h be=%b we=%b wd=%h want 100/1111/1/deadbeef", c_addr[1], c_be[1], c_we[1], c_wd[1]);
    end
    n_cmp++;
    if (c_we[2] !== 1'b0 || r_rdata !== 32'h0 || r_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sw_resp: got we=%b rdata=%h err=%b want 0/0/0", c_we[2], r_rdata, r_err);
    end
    n_cmp++;
    if (mem_words[64] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL sw_mem: got %h want deadbeef", mem_words[64]);
    end
    run_access(1'b0, 3'b010, 32'h100, 32'h0, lat);
    n_cmp++;
    if (lat !== 2 || r_rdata !== 32'hDEAD_BEEF || c_we[1] !== 1'b0 || c_be[1] !== 4'hF) begin
      n_fail++; $display("[TB] FAIL lw: got lat=%0d rdata=%h we=%b be=%b want 2/deadbeef/0/1111", lat, r_rdata, c_we[1], c_be[1]);
    end
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL lw_hold: got vld=%b rdata=%h want 0/deadbeef", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_split_store;
    int lat;
    run_access(1'b1, 3'b001, 32'h203, 32'h0000_A1B2, lat);
    n_cmp++;
    if (lat !== 3) begin
      n_fail++; $display("[TB] FAIL sh_split_latency: got %0d want 3", lat);
    end
    n_cmp++;
    if (c_addr[1] !== 32'h200 || c_be[1] !== 4'b1000 || c_wd[1][31:24] !== 8'hB2 || c_we[1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sh_split_acc0: got addr=%h be=%b byte=%h we=%b want 200/1000/b2/1", c_addr[1], c_be[1], c_wd[1][31:24], c_we[1]);
    end
    n_cmp++;
    if (c_addr[2] !== 32'h204 || c_be[2] !== 4'b0001 || c_wd[2][7:0] !== 8'hA1 || c_we[2] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sh_split_acc1: got addr=%h be=%b byte=%h we=%b want 204/0001/a1/1", c_addr[2], c_be[2], c_wd[2][7:0], c_we[2]);
    end
    n_cmp++;
    if (mem_words[128][31:24] !== 8'hB2 || mem_words[129][7:0] !== 8'hA1) begin
      n_fail++; $display("[TB] FAIL sh_split_mem: got %h/%h want b2/a1", mem_words[128][31:24], mem_words[129][7:0]);
    end
  endtask

  task automatic test_load_extend;
    int lat;
    logic [2:0]  f3  [7] = '{3'b001, 3'b000, 3'b100, 3'b101, 3'b010, 3'b001, 3'b010};
    logic [31:0] ad  [7] = '{32'h203, 32'h203, 32'h203, 32'h202, 32'h201, 32'h202, 32'h204};
    logic [31:0] exp [7] = '{32'h0000_1280, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                             32'h1280_FF00, 32'hFFFF_80FF, 32'h0000_0012};
    int          el  [7] = '{3, 2, 2, 2, 3, 2, 2};
    run_access(1'b1, 3'b010, 32'h200, 32'h80FF_0000, lat);
    run_access(1'b1, 3'b010, 32'h204, 32'h0000_0012, lat);
    for (int i = 0; i < 7; i++) begin
      run_access(1'b0, f3[i], ad[i], 32'h0, lat);
      n_cmp++;
      if (lat !== el[i] || r_rdata !== exp[i] || r_err !== 1'b0) begin
        n_fail++; $display("[TB] FAIL load_ext[%0d]: got lat=%0d rdata=%h err=%b want %0d/%h/0", i, lat, r_rdata, r_err, el[i], exp[i]);
      end
    end
  endtask

  task automatic test_illegal;
    int lat;
    logic       iwe [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0] if3 [3] = '{3'b011, 3'b110, 3'b100};
    for (int i = 0; i < 3; i++) begin
      run_access(iwe[i], if3[i], 32'h100, 32'h1234_5678, lat);
      n_cmp++;
      if (lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
        n_fail++; $display("[TB] FAIL illegal[%0d]: got lat=%0d err=%b rdata=%h want 1/1/0", i, lat, r_err, r_rdata);
      end
      n_cmp++;
      if (c_we[1] !== 1'b0 || c_be[1] !== 4'h0) begin
        n_fail++; $display("[TB] FAIL illegal_mem[%0d]: got we=%b be=%b want 0/0000", i, c_we[1], c_be[1]);
      end
    end
    n_cmp++;
    if (mem_words[64] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL illegal_nowrite: got %h want deadbeef", mem_words[64]);
    end
    run_access(1'b0, 3'b010, 32'h100, 32'h0, lat);
    n_cmp++;
    if (r_err !== 1'b0 || r_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL err_clear: got err=%b rdata=%h want 0/deadbeef", r_err, r_rdata);
    end
  endtask

  task automatic test_wrap;
    int lat;
    run_access(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h3400_0000, lat);
    run_access(1'b1, 3'b010, 32'h0000_0000, 32'h0000_00F2, lat);
    run_access(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, lat);
    n_cmp++;
    if (lat !== 3 || c_addr[1] !== 32'hFFFF_FFFC || c_be[1] !== 4'b1000) begin
      n_fail++; $display("[TB] FAIL wrap_acc0: got lat=%0d addr=%h be=%b want 3/fffffffc/1000", lat, c_addr[1], c_be[1]);
    end
    n_cmp++;
    if (c_addr[2] !== 32'h0 || c_be[2] !== 4'b0001 || c_we[2] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wrap_acc1: got addr=%h be=%b we=%b want 0/0001/0", c_addr[2], c_be[2], c_we[2]);
    end
    n_cmp++;
    if (r_rdata !== 32'hFFFF_F234) begin
      n_fail++; $display("[TB] FAIL wrap_data: got %h want fffff234", r_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_ready: got %b want 1", req_ready);
    end
    run_access(1'b1, 3'b000, 32'h101, 32'h0000_005A, lat);
    n_cmp++;
    if (lat !== 2 || c_be[1] !== 4'b0010 || c_wd[1][15:8] !== 8'h5A) begin
      n_fail++; $display("[TB] FAIL b2b_sb: got lat=%0d be=%b byte=%h want 2/0010/5a", lat, c_be[1], c_wd[1][15:8]);
    end
    run_access(1'b0, 3'b010, 32'h100, 32'h0, lat);
    n_cmp++;
    if (r_rdata !== 32'hDEAD_5AEF) begin
      n_fail++; $display("[TB] FAIL b2b_lw: got %h want dead5aef", r_rdata);
    end
  endtask

  task automatic test_reset_during_acc1;
    int lat;
    run_access(1'b1, 3'b010, 32'h100, 32'h1111_1111, lat);
    run_access(1'b1, 3'b010, 32'h104, 32'h2222_2222, lat);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h102;
    req_wdata  = 32'hAABB_CCDD;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (mem_addr !== 32'h100 || mem_be !== 4'b1100 || mem_we !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_acc0: got addr=%h be=%b we=%b want 100/1100/1", mem_addr, mem_be, mem_we);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (mem_addr !== 32'h104 || mem_be !== 4'b0011 || mem_we !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_acc1: got addr=%h be=%b we=%b want 104/0011/1", mem_addr, mem_be, mem_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_be !== 4'h0) begin
      n_fail++; $display("[TB] FAIL rst_async_drop: got we=%b be=%b want 0/0000", mem_we, mem_be);
    end
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_release: got rdy=%b vld=%b want 1/0", req_ready, resp_valid);
    end
    n_cmp++;
    if (mem_words[64] !== 32'hCCDD_1111 || mem_words[65] !== 32'h2222_2222) begin
      n_fail++; $display("[TB] FAIL rst_partial_write: got %h/%h want ccdd1111/22222222", mem_words[64], mem_words[65]);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_split_store();
    test_load_extend();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_during_acc1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
